// File: rtl/arqui_flow_ctrl_fsm.sv
// Flow controller for the arqui datapath (Main FIFO -> VC FIFOs -> D FIFOs): sequences init,
// distributes FIFO thresholds, tracks traffic state, latches FIFO errors and drives backpressure.
module arqui_flow_ctrl_fsm #(
    parameter int MF_TH_W = 2,
    parameter int VC_TH_W = 4,
    parameter int N_FIFO  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [MF_TH_W-1:0] afMF_i,
    input  logic [MF_TH_W-1:0] aeMF_i,
    input  logic [VC_TH_W-1:0] afVC_i,
    input  logic [VC_TH_W-1:0] aeVC_i,
    input  logic [MF_TH_W-1:0] afDF_i,
    input  logic [MF_TH_W-1:0] aeDF_i,
    input  logic [N_FIFO-1:0]  fifo_empty,
    input  logic [N_FIFO-1:0]  fifo_error,
    input  logic [1:0]         vc_afull,
    input  logic [1:0]         d_afull,
    output logic [MF_TH_W-1:0] afMF_o,
    output logic [MF_TH_W-1:0] aeMF_o,
    output logic [VC_TH_W-1:0] afVC_o,
    output logic [VC_TH_W-1:0] aeVC_o,
    output logic [MF_TH_W-1:0] afDF_o,
    output logic [MF_TH_W-1:0] aeDF_o,
    output logic [2:0]         state_out,
    output logic               active_out,
    output logic               idle_out,
    output logic [N_FIFO-1:0]  error_out,
    output logic               cfg_err,
    output logic               pause_main,
    output logic               pause_vc
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   cfg_legal;
    logic   any_error;

    assign cfg_legal = (aeMF_i < afMF_i) && (aeVC_i < afVC_i) && (aeDF_i < afDF_i);
    assign any_error = |fifo_error;
    assign state_out = state_reg;

    // Errors outrank init, which outranks the empty-flag driven traffic transitions.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET: state_next = ST_INIT;
            ST_INIT: begin
                if (any_error)
                    state_next = ST_ERROR;
                else if (!init && cfg_legal)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_error)
                    state_next = ST_ERROR;
                else if (init)
                    state_next = ST_INIT;
                else if (!(&fifo_empty))
                    state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_error)
                    state_next = ST_ERROR;
                else if (init)
                    state_next = ST_INIT;
                else if (&fifo_empty)
                    state_next = ST_IDLE;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_RESET;
            afMF_o     <= '0;
            aeMF_o     <= '0;
            afVC_o     <= '0;
            aeVC_o     <= '0;
            afDF_o     <= '0;
            aeDF_o     <= '0;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_out <= (state_next == ST_ACTIVE);
            idle_out   <= (state_next == ST_IDLE);
            if (state_reg != ST_RESET)
                error_out <= error_out | fifo_error;
            // Thresholds track the inputs only while configuring; frozen everywhere else.
            if (state_reg == ST_INIT) begin
                afMF_o  <= afMF_i;
                aeMF_o  <= aeMF_i;
                afVC_o  <= afVC_i;
                aeVC_o  <= aeVC_i;
                afDF_o  <= afDF_i;
                aeDF_o  <= aeDF_i;
                cfg_err <= !cfg_legal;
            end
        end
    end

    // Backpressure is combinational so downstream almost-full stops traffic in the same cycle.
    always_comb begin
        pause_main = 1'b1;
        pause_vc   = 1'b1;
        if (state_reg == ST_IDLE || state_reg == ST_ACTIVE) begin
            pause_main = |vc_afull;
            pause_vc   = |d_afull;
        end
    end

endmodule

// File: tb/tb_arqui_flow_ctrl_fsm.sv
// Directed bench for arqui_flow_ctrl_fsm: walks init, traffic, error, config and backpressure paths.
module tb_arqui_flow_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [1:0] afMF_i, aeMF_i, afDF_i, aeDF_i;
    logic [3:0] afVC_i, aeVC_i;
    logic [4:0] fifo_empty, fifo_error;
    logic [1:0] vc_afull, d_afull;
    logic [1:0] afMF_o, aeMF_o, afDF_o, aeDF_o;
    logic [3:0] afVC_o, aeVC_o;
    logic [2:0] state_out;
    logic       active_out, idle_out, cfg_err, pause_main, pause_vc;
    logic [4:0] error_out;

    int checks = 0;
    int errors = 0;

    arqui_flow_ctrl_fsm dut (
        .clk(clk), .reset(reset), .init(init),
        .afMF_i(afMF_i), .aeMF_i(aeMF_i), .afVC_i(afVC_i), .aeVC_i(aeVC_i),
        .afDF_i(afDF_i), .aeDF_i(aeDF_i),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error),
        .vc_afull(vc_afull), .d_afull(d_afull),
        .afMF_o(afMF_o), .aeMF_o(aeMF_o), .afVC_o(afVC_o), .aeVC_o(aeVC_o),
        .afDF_o(afDF_o), .aeDF_o(aeDF_o),
        .state_out(state_out), .active_out(active_out), .idle_out(idle_out),
        .error_out(error_out), .cfg_err(cfg_err),
        .pause_main(pause_main), .pause_vc(pause_vc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t state=%0d act=%0b idle=%0b err=%b cfg_err=%0b", $time, state_out,
                 active_out, idle_out, error_out, cfg_err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        checks++; if ({active_out, idle_out, cfg_err, error_out} !== 8'd0) begin errors++; $display("FAIL reset_outs got=%b exp=0", {active_out, idle_out, cfg_err, error_out}); end
        checks++; if ({afMF_o, aeMF_o, afVC_o, aeVC_o, afDF_o, aeDF_o} !== 16'd0) begin errors++; $display("FAIL reset_thr got=%h exp=0", {afMF_o, aeMF_o, afVC_o, aeVC_o, afDF_o, aeDF_o}); end
        checks++; if ({pause_main, pause_vc} !== 2'b11) begin errors++; $display("FAIL reset_pause got=%b exp=11", {pause_main, pause_vc}); end
        reset = 1'b0;
        step();
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL to_init got=%0d exp=1", state_out); end
        step();
        checks++; if (state_out !== 3'd2 || idle_out !== 1'b1) begin errors++; $display("FAIL to_idle state=%0d idle=%0b exp 2/1", state_out, idle_out); end
        checks++; if ({afMF_o, aeMF_o, afVC_o, aeVC_o, afDF_o, aeDF_o} !== 16'b11_01_1110_0010_11_01) begin errors++; $display("FAIL thr_load got=%b exp=1101111000101101", {afMF_o, aeMF_o, afVC_o, aeVC_o, afDF_o, aeDF_o}); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_ok got=%0b exp=0", cfg_err); end
    endtask

    task automatic test_traffic();
        fifo_empty = 5'b11110;
        step();
        checks++; if (state_out !== 3'd3 || active_out !== 1'b1 || idle_out !== 1'b0) begin errors++; $display("FAIL to_active state=%0d act=%0b idle=%0b exp 3/1/0", state_out, active_out, idle_out); end
        fifo_empty = 5'b11111;
        step();
        checks++; if (state_out !== 3'd2 || active_out !== 1'b0 || idle_out !== 1'b1) begin errors++; $display("FAIL back_idle state=%0d act=%0b idle=%0b exp 2/0/1", state_out, active_out, idle_out); end
        afMF_i = 2'b10;
        step();
        checks++; if (afMF_o !== 2'b11) begin errors++; $display("FAIL thr_frozen got=%b exp=11", afMF_o); end
        afMF_i = 2'b11;
    endtask

    task automatic test_pause();
        fifo_empty = 5'b10111;
        step();
        checks++; if (state_out !== 3'd3 || {pause_main, pause_vc} !== 2'b00) begin errors++; $display("FAIL pause_idle state=%0d pause=%b exp 3/00", state_out, {pause_main, pause_vc}); end
        vc_afull = 2'b01;
        #1;
        checks++; if ({pause_main, pause_vc} !== 2'b10) begin errors++; $display("FAIL pause_vc_afull got=%b exp=10", {pause_main, pause_vc}); end
        d_afull = 2'b10;
        #1;
        checks++; if ({pause_main, pause_vc} !== 2'b11) begin errors++; $display("FAIL pause_d_afull got=%b exp=11", {pause_main, pause_vc}); end
        vc_afull = 2'b00;
        d_afull  = 2'b00;
        #1;
        checks++; if ({pause_main, pause_vc} !== 2'b00) begin errors++; $display("FAIL pause_clear got=%b exp=00", {pause_main, pause_vc}); end
    endtask

    task automatic test_cfg();
        init = 1'b1;
        step();
        checks++; if (state_out !== 3'd1 || {pause_main, pause_vc} !== 2'b11) begin errors++; $display("FAIL reinit state=%0d pause=%b exp 1/11", state_out, {pause_main, pause_vc}); end
        init = 1'b0; aeVC_i = 4'b1110; afVC_i = 4'b0010;
        step();
        checks++; if (state_out !== 3'd1 || cfg_err !== 1'b1 || afVC_o !== 4'b0010) begin errors++; $display("FAIL bad_cfg state=%0d cfg_err=%0b afVC=%b exp 1/1/0010", state_out, cfg_err, afVC_o); end
        aeVC_i = 4'b0010; afVC_i = 4'b1110; fifo_empty = 5'b11111;
        step();
        checks++; if (state_out !== 3'd2 || cfg_err !== 1'b0) begin errors++; $display("FAIL fixed_cfg state=%0d cfg_err=%0b exp 2/0", state_out, cfg_err); end
        init = 1'b1;
        step();
        init = 1'b0; aeMF_i = 2'b11;
        step();
        checks++; if (state_out !== 3'd1 || cfg_err !== 1'b1) begin errors++; $display("FAIL equal_thr state=%0d cfg_err=%0b exp 1/1", state_out, cfg_err); end
        aeMF_i = 2'b01;
        step();
        checks++; if (state_out !== 3'd2 || cfg_err !== 1'b0 || aeMF_o !== 2'b01) begin errors++; $display("FAIL equal_fix state=%0d cfg_err=%0b aeMF=%b exp 2/0/01", state_out, cfg_err, aeMF_o); end
    endtask

    task automatic test_error();
        fifo_empty = 5'b11110;
        step();
        fifo_error = 5'b00100;
        step();
        checks++; if (state_out !== 3'd4 || error_out !== 5'b00100 || active_out !== 1'b0) begin errors++; $display("FAIL to_error state=%0d err=%b act=%0b exp 4/00100/0", state_out, error_out, active_out); end
        fifo_error = 5'b00000; init = 1'b1;
        step();
        checks++; if (state_out !== 3'd4 || error_out !== 5'b00100) begin errors++; $display("FAIL err_sticky state=%0d err=%b exp 4/00100", state_out, error_out); end
        checks++; if ({pause_main, pause_vc} !== 2'b11) begin errors++; $display("FAIL err_pause got=%b exp=11", {pause_main, pause_vc}); end
        init = 1'b0; fifo_error = 5'b00001;
        step();
        checks++; if (error_out !== 5'b00101) begin errors++; $display("FAIL err_accum got=%b exp=00101", error_out); end
        fifo_error = 5'b00000;
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset = 1'b0; fifo_empty = 5'b11110;
        step();
        step();
        step();
        checks++; if (state_out !== 3'd3 || error_out !== 5'd0) begin errors++; $display("FAIL rerun_active state=%0d err=%b exp 3/00000", state_out, error_out); end
        init = 1'b1; fifo_empty = 5'b11111;
        step();
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL init_vs_empty got=%0d exp=1", state_out); end
        init = 1'b0;
        step();
        fifo_empty = 5'b01111;
        step();
        #3;
        reset = 1'b1;
        #1;
        checks++; if (state_out !== 3'd0 || active_out !== 1'b0 || afVC_o !== 4'd0) begin errors++; $display("FAIL async_reset state=%0d act=%0b afVC=%b exp 0/0/0000", state_out, active_out, afVC_o); end
        checks++; if (pause_main !== 1'b1) begin errors++; $display("FAIL async_pause got=%0b exp=1", pause_main); end
        step();
        reset = 1'b0;
        step();
        init = 1'b1; fifo_error = 5'b00010;
        step();
        checks++; if (state_out !== 3'd4 || error_out !== 5'b00010) begin errors++; $display("FAIL err_over_init state=%0d err=%b exp 4/00010", state_out, error_out); end
        init = 1'b0; fifo_error = 5'b00000;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0;
        afMF_i = 2'b11; aeMF_i = 2'b01;
        afVC_i = 4'b1110; aeVC_i = 4'b0010;
        afDF_i = 2'b11; aeDF_i = 2'b01;
        fifo_empty = 5'b11111; fifo_error = 5'b00000;
        vc_afull = 2'b00; d_afull = 2'b00;
        test_reset();
        test_traffic();
        test_pause();
        test_cfg();
        test_error();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
